// File: rtl/wb_collector_if.sv
// wb_collector_if: result channels from the execution units and write ports to the register file
interface wb_collector_if #(
  parameter int Source_Port = 6,
  parameter int Write_Port  = 4,
  parameter int Width       = 32,
  parameter int AW          = 6
);
  logic [Source_Port-1:0]            In_Valid;
  logic [Source_Port-1:0][AW-1:0]    In_Addr;
  logic [Source_Port-1:0][Width-1:0] In_Data;
  logic                              In_Ready;
  logic [Write_Port-1:0][AW-1:0]     WA;
  logic [Write_Port-1:0][Width-1:0]  WD;
  logic [Write_Port-1:0]             We;
  modport master (output In_Valid, In_Addr, In_Data, input In_Ready, WA, WD, We);
  modport slave  (input In_Valid, In_Addr, In_Data, output In_Ready, WA, WD, We);
endinterface

// File: rtl/wb_collector.sv
// wb_collector: in-order writeback queue packing execution results and draining them onto register-file write ports
module wb_collector #(
  parameter int Source_Port = 6,
  parameter int Write_Port  = 4,
  parameter int Width       = 32,
  parameter int Depth       = 64,
  parameter int Queue_Depth = 16
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic                         Flush,
  wb_collector_if.slave                bus,
  output logic [$clog2(Queue_Depth):0] Count,
  output logic                         Empty
);
  localparam int AW  = $clog2(Depth);
  localparam int QAW = $clog2(Queue_Depth);
  localparam int CW  = QAW + 1;
  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [Width-1:0] data;
  } entry_t;
  entry_t                          mem_q [Queue_Depth];
  logic [QAW-1:0]                  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]                   count_q, count_d, drain_n, enq_n;
  logic [Source_Port-1:0]          acc;
  logic [QAW-1:0]                  off [Source_Port];
  logic [Write_Port-1:0][AW-1:0]   wa_q;
  logic [Write_Port-1:0][Width-1:0] wd_q;
  logic [Write_Port-1:0]           we_q;
  logic                            ready;
  // Room for a full set of results is judged from registered occupancy only
  assign ready        = count_q <= CW'(Queue_Depth - Source_Port);
  assign bus.In_Ready = ready;
  assign bus.WA       = wa_q;
  assign bus.WD       = wd_q;
  assign bus.We       = we_q;
  assign Count        = count_q;
  assign Empty        = count_q == '0 && we_q == '0;
  // Pack accepted non-zero-address results behind tail in channel order; drain up to Write_Port oldest
  always_comb begin
    enq_n = '0;
    for (int i = 0; i < Source_Port; i++) begin
      acc[i] = bus.In_Valid[i] && ready && bus.In_Addr[i] != '0;
      off[i] = tail_q + enq_n[QAW-1:0];
      enq_n  = enq_n + CW'(acc[i]);
    end
    drain_n = count_q < CW'(Write_Port) ? count_q : CW'(Write_Port);
    head_d  = head_q + drain_n[QAW-1:0];
    tail_d  = tail_q + enq_n[QAW-1:0];
    count_d = count_q + enq_n - drain_n;
  end
  // Queue storage; slots past tail are never read, so no reset is needed
  always_ff @(posedge Clk) begin
    for (int i = 0; i < Source_Port; i++)
      if (acc[i]) mem_q[off[i]] <= {bus.In_Addr[i], bus.In_Data[i]};
  end
  // Pointers, occupancy and registered write ports; flush wins over enqueue and drain
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we_q    <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else if (Flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we_q    <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int k = 0; k < Write_Port; k++) begin
        we_q[k] <= CW'(k) < drain_n;
        if (CW'(k) < drain_n) begin
          wa_q[k] <= mem_q[head_q + QAW'(k)].addr;
          wd_q[k] <= mem_q[head_q + QAW'(k)].data;
        end
      end
    end
  end
endmodule

// File: tb/tb_wb_collector.sv
// tb_wb_collector: randomized and directed checks of wb_collector against a queue-based reference model
module tb_wb_collector;
  typedef struct packed {
    logic [5:0]  a;
    logic [31:0] d;
  } ent_t;
  logic clk = 0, Rst_n = 0, Flush = 0;
  logic [4:0] Count;
  logic       Empty;
  int checks = 0, errors = 0;
  ent_t mq[$];
  logic [3:0]       m_we;
  logic [3:0][5:0]  m_wa;
  logic [3:0][31:0] m_wd;
  logic [31:0] m_rf [64];
  logic [31:0] d_rf [64];
  int d_writes = 0, m_acc = 0;
  bit wrote0 = 0;

  wb_collector_if #(.Source_Port(6), .Write_Port(4), .Width(32), .AW(6)) bus ();
  wb_collector #(.Source_Port(6), .Write_Port(4), .Width(32), .Depth(64), .Queue_Depth(16)) dut (
    .Clk(clk), .Rst_n(Rst_n), .Flush(Flush), .bus(bus), .Count(Count), .Empty(Empty));

  always #5 clk = ~clk;

  // Register file fed by the DUT ports; highest port wins on same address
  always @(posedge clk)
    for (int k = 0; k < 4; k++)
      if (bus.We[k] === 1'b1) begin
        d_rf[bus.WA[k]] = bus.WD[k];
        d_writes++;
        if (bus.WA[k] == 6'd0) wrote0 = 1;
      end

  task automatic step(input logic fl);
    int n;
    ent_t e;
    bit rdy;
    rdy = (16 - mq.size()) >= 6;
    Flush = fl;
    for (int k = 0; k < 4; k++) if (m_we[k]) m_rf[m_wa[k]] = m_wd[k];
    if (fl) begin
      mq.delete();
      m_we = '0;
    end else begin
      n = mq.size() < 4 ? mq.size() : 4;
      for (int k = 0; k < 4; k++) begin
        m_we[k] = k < n;
        if (k < n) begin
          e = mq.pop_front();
          m_wa[k] = e.a;
          m_wd[k] = e.d;
        end
      end
      if (rdy)
        for (int i = 0; i < 6; i++)
          if (bus.In_Valid[i] && bus.In_Addr[i] != 6'd0) begin
            mq.push_back({bus.In_Addr[i], bus.In_Data[i]});
            m_acc++;
          end
    end
    @(posedge clk);
    @(negedge clk);
    Flush = 0;
  endtask

  task automatic set_rand(input int pct);
    for (int i = 0; i < 6; i++) begin
      bus.In_Valid[i] = $urandom_range(99) < pct;
      bus.In_Addr[i]  = $urandom_range(7) == 0 ? 6'd0 : 6'($urandom_range(63));
      bus.In_Data[i]  = $urandom;
    end
  endtask

  task automatic idle();
    bus.In_Valid = '0;
  endtask

  task automatic test_reset();
    set_rand(100);
    step(0);
    step(0);
    #2 Rst_n = 0;
    #1;
    checks++; if (bus.We !== 4'h0) begin errors++; $display("FAIL reset_we: got %h expected 0", bus.We); end
    checks++; if (Count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", Count); end
    checks++; if (bus.In_Ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.In_Ready); end
    checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", Empty); end
    checks++; if (bus.WA !== '0 || bus.WD !== '0) begin errors++; $display("FAIL reset_wa_wd: got %h/%h expected 0", bus.WA, bus.WD); end
    mq.delete();
    m_we = '0;
    m_wa = '0;
    m_wd = '0;
    idle();
    @(negedge clk);
    Rst_n = 1;
  endtask

  task automatic test_single();
    bus.In_Valid = 6'b000100;
    bus.In_Addr[2] = 6'd5;
    bus.In_Data[2] = 32'hDEADBEEF;
    step(0);
    idle();
    checks++; if (Count !== 5'd1 || bus.We !== 4'h0) begin errors++; $display("FAIL single_accept: got count %0d we %h expected 1/0", Count, bus.We); end
    step(0);
    checks++; if (bus.We !== 4'b0001) begin errors++; $display("FAIL single_we: got %b expected 0001", bus.We); end
    checks++; if (bus.WA[0] !== 6'd5 || bus.WD[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_port0: got %0d/%h expected 5/deadbeef", bus.WA[0], bus.WD[0]); end
    checks++; if (Empty !== 1'b0) begin errors++; $display("FAIL single_empty_busy: got %b expected 0", Empty); end
    step(0);
    checks++; if (d_rf[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rf: got %h expected deadbeef", d_rf[5]); end
    checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL single_empty_idle: got %b expected 1", Empty); end
  endtask

  task automatic test_burst();
    int cnt[5] = '{6, 8, 4, 0, 0};
    int bad;
    for (int s = 0; s < 5; s++) begin
      if (s < 2)
        for (int i = 0; i < 6; i++) begin
          bus.In_Valid[i] = 1;
          bus.In_Addr[i]  = 6'(i + 1);
          bus.In_Data[i]  = $urandom;
        end
      else idle();
      step(0);
      checks++; if (Count !== 5'(cnt[s])) begin errors++; $display("FAIL burst_count[%0d]: got %0d expected %0d", s, Count, cnt[s]); end
      checks++; if (bus.We !== ((s >= 1 && s <= 3) ? 4'hF : 4'h0)) begin errors++; $display("FAIL burst_we[%0d]: got %h", s, bus.We); end
      if (s >= 1 && s <= 3)
        for (int k = 0; k < 4; k++) begin
          checks++; if (bus.WA[k] !== 6'(((s - 1) * 4 + k) % 6 + 1)) begin errors++; $display("FAIL burst_wa[%0d][%0d]: got %0d expected %0d", s, k, bus.WA[k], ((s - 1) * 4 + k) % 6 + 1); end
        end
      checks++; if (bus.WD !== m_wd) begin errors++; $display("FAIL burst_wd[%0d]: got %h expected %h", s, bus.WD, m_wd); end
    end
    bad = 0;
    for (int r = 0; r < 64; r++) if (d_rf[r] !== m_rf[r]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL burst_rf: %0d registers differ, expected 0", bad); end
  endtask

  task automatic test_backpressure();
    int w0, a0, c;
    bit saw;
    w0 = d_writes;
    a0 = m_acc;
    saw = 0;
    for (c = 0; c < 20 && !saw; c++) begin
      for (int i = 0; i < 6; i++) begin
        bus.In_Valid[i] = 1;
        bus.In_Addr[i]  = 6'($urandom_range(63, 1));
        bus.In_Data[i]  = $urandom;
      end
      step(0);
      checks++; if (Count !== 5'(mq.size())) begin errors++; $display("FAIL bp_count: got %0d expected %0d", Count, mq.size()); end
      if (mq.size() >= 11) begin
        saw = 1;
        checks++; if (bus.In_Ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b expected 0 at count %0d", bus.In_Ready, mq.size()); end
      end
    end
    checks++; if (!saw) begin errors++; $display("FAIL bp_timeout: occupancy never reached 11 within %0d cycles", c); end
    step(0);
    checks++; if (Count !== 5'(mq.size())) begin errors++; $display("FAIL bp_hold: got %0d expected %0d", Count, mq.size()); end
    idle();
    for (int j = 0; j < 6; j++) step(0);
    checks++; if (d_writes - w0 != m_acc - a0) begin errors++; $display("FAIL bp_total: got %0d writes expected %0d", d_writes - w0, m_acc - a0); end
  endtask

  task automatic test_zero_same();
    idle();
    bus.In_Valid[2:0] = 3'b111;
    bus.In_Addr[0] = 6'd0;  bus.In_Data[0] = 32'hBAD0BAD0;
    bus.In_Addr[1] = 6'd9;  bus.In_Data[1] = 32'd1;
    bus.In_Addr[2] = 6'd9;  bus.In_Data[2] = 32'd2;
    step(0);
    idle();
    checks++; if (Count !== 5'd2) begin errors++; $display("FAIL zero_count: got %0d expected 2", Count); end
    step(0);
    checks++; if (bus.We !== 4'b0011) begin errors++; $display("FAIL zero_we: got %b expected 0011", bus.We); end
    checks++; if (bus.WA[0] !== 6'd9 || bus.WD[0] !== 32'd1 || bus.WA[1] !== 6'd9 || bus.WD[1] !== 32'd2) begin errors++; $display("FAIL same_order: got %0d/%0h %0d/%0h expected 9/1 9/2", bus.WA[0], bus.WD[0], bus.WA[1], bus.WD[1]); end
    step(0);
    checks++; if (d_rf[9] !== 32'd2) begin errors++; $display("FAIL same_rf: got %0h expected 2", d_rf[9]); end
    checks++; if (wrote0) begin errors++; $display("FAIL zero_write: got a write to reg 0 expected none"); end
  endtask

  task automatic test_flush();
    int w, bad;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 6; i++) begin
        bus.In_Valid[i] = 1;
        bus.In_Addr[i]  = 6'($urandom_range(63, 1));
        bus.In_Data[i]  = $urandom;
      end
      step(0);
    end
    checks++; if (Count !== 5'd8) begin errors++; $display("FAIL flush_pre: got %0d expected 8", Count); end
    idle();
    for (int i = 0; i < 3; i++) begin
      bus.In_Valid[i] = 1;
      bus.In_Addr[i]  = 6'(40 + i);
      bus.In_Data[i]  = 32'hF1F10000 | i;
    end
    step(1);
    idle();
    checks++; if (Count !== 5'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", Count); end
    checks++; if (bus.We !== 4'h0) begin errors++; $display("FAIL flush_we: got %h expected 0", bus.We); end
    w = d_writes;
    for (int j = 0; j < 3; j++) step(0);
    checks++; if (d_writes != w) begin errors++; $display("FAIL flush_leak: got %0d writes expected 0", d_writes - w); end
    bad = 0;
    for (int r = 0; r < 64; r++) if (d_rf[r] !== m_rf[r]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL flush_rf: %0d registers differ, expected 0", bad); end
  endtask

  task automatic test_random();
    int bad;
    for (int c = 0; c < 300; c++) begin
      set_rand(c % 50 < 25 ? 80 : 30);
      step($urandom_range(39) == 0);
      checks++; if (Count !== 5'(mq.size())) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", c, Count, mq.size()); end
      checks++; if (bus.In_Ready !== ((16 - mq.size()) >= 6)) begin errors++; $display("FAIL rnd_ready[%0d]: got %b", c, bus.In_Ready); end
      checks++; if (bus.We !== m_we) begin errors++; $display("FAIL rnd_we[%0d]: got %h expected %h", c, bus.We, m_we); end
      checks++; if (bus.WA !== m_wa || bus.WD !== m_wd) begin errors++; $display("FAIL rnd_ports[%0d]: got %h/%h expected %h/%h", c, bus.WA, bus.WD, m_wa, m_wd); end
      checks++; if (Empty !== (mq.size() == 0 && m_we == 4'h0)) begin errors++; $display("FAIL rnd_empty[%0d]: got %b", c, Empty); end
    end
    idle();
    for (int j = 0; j < 6; j++) step(0);
    bad = 0;
    for (int r = 0; r < 64; r++) if (d_rf[r] !== m_rf[r]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rnd_rf: %0d registers differ, expected 0", bad); end
  endtask

  initial begin
    bus.In_Valid = '0;
    bus.In_Addr  = '0;
    bus.In_Data  = '0;
    m_we = '0;
    m_wa = '0;
    m_wd = '0;
    for (int r = 0; r < 64; r++) begin
      m_rf[r] = '0;
      d_rf[r] = '0;
    end
    @(negedge clk);
    Rst_n = 1;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_zero_same();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
